mult_div_unit: RTL and testbench

Multi-cycle 16-bit multiply/divide responder that sits beside the single-cycle ALU in the MIPS datapath. It supplies the HI/LO results for mult/div instructions. The control unit acts as initiator: it presents operands plus an op code, pulses start, and waits for done. Results are produced iteratively, one shift-add or one restoring-divide step per clock, and held in HI/LO until the next accepted request.

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_step.sv | 52 +++++
 rtl/mult_div_unit.sv | 116 +++++++++++
 tb/tb_mult_div_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   op_e      : request op code carried on the 'op' port
//   state_e   : sequencing states of mult_div_unit
//   DIV0_QUOT : quotient reported for a divide by zero
package mdu_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [WIDTH_DEFAULT-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
//   hi_i, lo_i : current working registers
//   operand_i  : multiplicand (multiply) or divisor (divide)
//   op_i       : OP_MULT = shift-add step, OP_DIV = restoring-divide step
//   hi_o, lo_o : working registers after this step
module mdu_step
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] operand_i,
  input  logic             op_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   partial;
  logic             fits;
  logic [WIDTH-1:0] diff;

  always_comb begin
    // Multiply: {carry, hi} = hi + (lo[0] ? a : 0), then the 33-bit value shifts right.
    addend  = lo_i[0] ? operand_i : '0;
    sum     = {1'b0, hi_i} + {1'b0, addend};

    // Divide: the bit shifted out of hi is kept as the 17th bit of the partial
    // remainder so divisors above 2**(WIDTH-1) still divide correctly.
    partial = {hi_i, lo_i[WIDTH-1]};
    fits    = (partial >= {1'b0, operand_i});
    // When fits is set the true difference is below the divisor, so the low
    // WIDTH bits of the subtraction are exact.
    diff    = partial[WIDTH-1:0] - operand_i;

    hi_o = hi_i;
    lo_o = lo_i;
    if (op_i == OP_MULT) begin
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end else if (fits) begin
      hi_o = diff;
      lo_o = {lo_i[WIDTH-2:0], 1'b1};
    end else begin
      hi_o = partial[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle unsigned multiply/divide unit producing HI/LO for mult/div.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start, op    : request strobe (accepted only in IDLE) and op code
//   a, b         : operands, captured when a request is accepted
//   busy         : high while iterating
//   done         : one-cycle completion pulse; hi/lo valid from then on
//   hi, lo       : multiply {upper, lower} product / divide {remainder, quotient}
//   div_by_zero  : flagged with done for a divide by zero
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  op_e              op_q, op_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] step_hi, step_lo;

  mdu_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .operand_i(opnd_q),
    .op_i     (op_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_DIV && b == '0) begin
            state_d = S_DONE;
            hi_d    = a;
            lo_d    = WIDTH'(DIV0_QUOT);
            dbz_d   = 1'b1;
          end else begin
            // The working registers double as the operand shift register:
            // lo starts as the multiplier or the dividend.
            state_d = S_RUN;
            hi_d    = '0;
            lo_d    = (op == OP_DIV) ? a : b;
            opnd_d  = (op == OP_DIV) ? b : a;
            op_d    = op_e'(op);
            dbz_d   = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      S_RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      op_q    <= OP_MULT;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random requests
// compared against an arithmetic reference (*, /, %).
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [15:0] a, b;
  logic        busy, done, div_by_zero;
  logic [15:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mult_div_unit #(
    .WIDTH(16),
    .CNT_W(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one request and check latency, busy length, results and done pulse.
  // intr_k >= 0 drives an extra (to be ignored) divide request at that RUN cycle.
  task automatic run_op(input string tag, input logic op_i, input logic [15:0] a_i,
                        input logic [15:0] b_i, input int intr_k);
    logic [31:0] prod;
    logic [15:0] exp_hi, exp_lo;
    logic        exp_dbz;
    int          exp_lat, lat, busy_cnt, extra_done;

    prod = {16'b0, a_i} * {16'b0, b_i};
    if (op_i == 1'b0) begin
      exp_hi = prod[31:16]; exp_lo = prod[15:0]; exp_dbz = 1'b0; exp_lat = 16;
    end else if (b_i == 16'd0) begin
      exp_hi = a_i; exp_lo = 16'hFFFF; exp_dbz = 1'b1; exp_lat = 0;
    end else begin
      exp_hi = a_i % b_i; exp_lo = a_i / b_i; exp_dbz = 1'b0; exp_lat = 16;
    end

    start = 1'b1; op = op_i; a = a_i; b = b_i;
    tick();
    start = 1'b0; op = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
    if (!exp_dbz) check({tag, ".dbz_clr"}, 32'(div_by_zero), 32'd0);

    lat = -1; busy_cnt = 0;
    for (int k = 0; k <= 40; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
      if (k == intr_k) begin
        start = 1'b1; op = 1'b1; a = 16'd9; b = 16'd3;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;

    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    check({tag, ".hi"}, 32'(hi), 32'(exp_hi));
    check({tag, ".lo"}, 32'(lo), 32'(exp_lo));
    check({tag, ".dbz"}, 32'(div_by_zero), 32'(exp_dbz));
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);

    extra_done = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done) extra_done++;
    end
    check({tag, ".single_done"}, 32'(extra_done), 32'd0);
    check({tag, ".hold"}, {hi, lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    int dones;
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    tick();
    tick();
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.hilo", {hi, lo}, 32'd0);
    check("rst.dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    tick();

    run_op("mul300x200", 1'b0, 16'd300, 16'd200, -1);
    run_op("mulmax", 1'b0, 16'hFFFF, 16'hFFFF, -1);
    run_op("div1000_7", 1'b1, 16'd1000, 16'd7, -1);
    run_op("div7_1000", 1'b1, 16'd7, 16'd1000, -1);
    run_op("div0", 1'b1, 16'h1234, 16'd0, -1);
    run_op("div_after0", 1'b1, 16'hFFFF, 16'h8001, -1);
    run_op("busy_start", 1'b0, 16'd3, 16'd5, 5);

    // Reset in the middle of an operation aborts it without a done.
    start = 1'b1; op = 1'b0; a = 16'd100; b = 16'd100;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid.busy", 32'(busy), 32'd0);
    check("rstmid.done", 32'(done), 32'd0);
    check("rstmid.hilo", {hi, lo}, 32'd0);
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done || busy) dones++;
    end
    check("rstmid.no_done", 32'(dones), 32'd0);
    run_op("mul2x3", 1'b0, 16'd2, 16'd3, -1);

    for (int i = 0; i < 40; i++) begin
      logic        r_op;
      logic [15:0] r_a, r_b;
      r_op = 1'($urandom_range(0, 1));
      r_a  = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       r_b = 16'd0;
        1:       r_b = 16'($urandom_range(1, 15));
        default: r_b = 16'($urandom);
      endcase
      run_op($sformatf("rnd%0d", i), r_op, r_a, r_b, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
